// File: rtl/chroni_vram_arbiter_if.sv
// Bus bundle between chroni, the CPU, the VRAM and the arbiter.
// The arbiter takes the slave view; the environment takes the master view.
interface chroni_vram_arbiter_if #(
  parameter int ADDR_W = 21
);
  logic [12:0]       vid_addr;
  logic [7:0]        vid_page;
  logic              vid_rd_req;
  logic              vid_rd_ack;
  logic [7:0]        vid_data;

  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_we;
  logic              cpu_re;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;

  modport slave (
    input  vid_addr, vid_page, vid_rd_req,
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
    input  mem_rdata,
    output vid_rd_ack, vid_data, cpu_rdata, cpu_ack,
    output mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output vid_addr, vid_page, vid_rd_req,
    output cpu_addr, cpu_wdata, cpu_we, cpu_re,
    output mem_rdata,
    input  vid_rd_ack, vid_data, cpu_rdata, cpu_ack,
    input  mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/chroni_vram_arbiter.sv
// Single-port VRAM arbiter: chroni video fetches have priority, and a waiting
// CPU access is forced through after MAX_VID_BURST consecutive video grants.
module chroni_vram_arbiter #(
  parameter int READ_LATENCY  = 1,
  parameter int MAX_VID_BURST = 4,
  parameter int ADDR_W        = 21
) (
  input  logic                 vga_clk,
  input  logic                 reset_n,
  chroni_vram_arbiter_if.slave bus
);
  localparam int               STV_W    = $clog2(MAX_VID_BURST + 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(MAX_VID_BURST);
  localparam logic [1:0]       LAT_LAST = 2'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VID_RD,
    S_CPU_RD,
    S_CPU_WR,
    S_ACK
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        wait_q, wait_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic              vid_ack_q, vid_ack_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [7:0]        vid_data_q, vid_data_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              cpu_pend;
  logic              vid_win;

  assign cpu_pend = bus.cpu_we | bus.cpu_re;
  assign vid_win  = bus.vid_rd_req & ~(cpu_pend & (starve_q == STV_MAX));

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    vid_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    vid_data_d  = vid_data_q;
    cpu_rdata_d = cpu_rdata_q;

    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (vid_win) begin
          state_d    = S_VID_RD;
          mem_addr_d = ADDR_W'({bus.vid_page, bus.vid_addr});
          mem_re_d   = 1'b1;
          if (!cpu_pend) begin
            starve_d = '0;
          end else if (starve_q != STV_MAX) begin
            starve_d = starve_q + STV_W'(1);
          end
        end else if (cpu_pend) begin
          starve_d   = '0;
          mem_addr_d = bus.cpu_addr;
          // Simultaneous write and read requests are served as a write.
          if (bus.cpu_we) begin
            state_d     = S_CPU_WR;
            mem_wdata_d = bus.cpu_wdata;
            mem_we_d    = 1'b1;
          end else begin
            state_d  = S_CPU_RD;
            mem_re_d = 1'b1;
          end
        end else begin
          starve_d = '0;
        end
      end
      S_VID_RD, S_CPU_RD: begin
        if (wait_q == LAT_LAST) begin
          state_d = S_ACK;
          if (state_q == S_VID_RD) begin
            vid_data_d = bus.mem_rdata;
            vid_ack_d  = 1'b1;
          end else begin
            cpu_rdata_d = bus.mem_rdata;
            cpu_ack_d   = 1'b1;
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_CPU_WR: begin
        state_d   = S_ACK;
        cpu_ack_d = 1'b1;
      end
      // One dead cycle so a requester can move its address on the ack edge.
      S_ACK:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      vid_ack_q   <= vid_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.vid_rd_ack = vid_ack_q;
  assign bus.vid_data   = vid_data_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
endmodule

// File: doc/chroni_vram_arbiter.md
Name: chroni_vram_arbiter

Overview:
- Single-port VRAM access arbiter upstream of the chroni display controller.
- Serves chroni's fetch handshake (rd_req / rd_ack with addr_out, addr_out_page, data_in) and CPU byte reads and writes against one synchronous-read VRAM.
- Video has priority. A starvation guard grants the CPU after a bounded run of video accesses.

Parameters:
READ_LATENCY, 1, cycles from the mem_re cycle to the cycle in which mem_rdata is valid (1..3).
MAX_VID_BURST, 4, consecutive video grants allowed while a CPU request waits.
ADDR_W, 21, VRAM byte address width ({page[7:0], addr[12:0]}).

Ports:
vga_clk  in  1  system/pixel clock; all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
vid_addr  in  13  chroni addr_out.
vid_page  in  8  chroni addr_out_page.
vid_rd_req  in  1  chroni read request (level).
vid_rd_ack  out  1  one-cycle pulse; vid_data valid in the same cycle.
vid_data  out  8  read data to chroni data_in; holds its value until the next video ack.
cpu_addr  in  ADDR_W  CPU VRAM byte address.
cpu_wdata  in  8  CPU write data.
cpu_we  in  1  CPU write request (level, held until cpu_ack).
cpu_re  in  1  CPU read request (level, held until cpu_ack).
cpu_rdata  out  8  CPU read data; valid in the cpu_ack cycle; held afterwards.
cpu_ack  out  1  one-cycle completion pulse.
mem_addr  out  ADDR_W  VRAM address (registered).
mem_wdata  out  8  VRAM write data (registered).
mem_we  out  1  VRAM write strobe, one cycle per write.
mem_re  out  1  VRAM read strobe, one cycle per read.
mem_rdata  in  8  VRAM read data.

Behaviour:
- Reset: async on reset_n low. State=IDLE. All outputs 0, including vid_data, cpu_rdata, mem_addr and mem_wdata. Starve counter 0. Any in-flight access is dropped with no ack; requesters reissue.
- States: IDLE, VID_RD, CPU_RD, CPU_WR, ACK.
- IDLE, arbitration is sampled on the clock edge:
  - cpu_pend = cpu_we | cpu_re.
  - Video wins if vid_rd_req=1 and !(cpu_pend && starve==MAX_VID_BURST).
  - Otherwise CPU wins if cpu_pend.
  - If cpu_we and cpu_re are both high, the request is a write.
- Video grant at edge E0:
  - mem_addr={vid_page,vid_addr} and mem_re=1 for cycle E0..E1.
  - At edge E1+READ_LATENCY, vid_data<=mem_rdata and vid_rd_ack=1 for exactly one cycle (state ACK).
  - Ack latency = READ_LATENCY+1 edges after the accept edge.
- CPU read: same timing as video, using cpu_addr; delivers cpu_rdata and cpu_ack.
- CPU write at edge E0:
  - mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=1 for one cycle.
  - cpu_ack=1 in the following cycle (state ACK).
- ACK -> IDLE unconditionally. IDLE must not sample a request during the ACK cycle. This turnaround lets the requester update its address on the ack edge (chroni changes addr_out on rd_ack), so the next sample sees the new address. Minimum video access period = READ_LATENCY+3 cycles.
- Starve counter:
  - Increments (saturating at MAX_VID_BURST) on each video grant while cpu_pend=1.
  - Clears on a CPU grant, or on any IDLE sample where cpu_pend=0.
- Requests dropped before grant are ignored; no ack is produced. A request deasserted after grant still completes and acks.
- mem_we and mem_re are never both high. At most one access is outstanding.
- Address width: {vid_page,vid_addr} is concatenated with no arithmetic. cpu_addr passes through unmodified.

Test Plan:
- Reset mid-read: assert reset_n=0 one cycle after a video grant -> vid_rd_ack never pulses; all outputs 0; after release, the next vid_rd_req is served normally.
- Single video read, READ_LATENCY=1, page=8'h02, addr=13'h0401, VRAM byte 8'h41 -> mem_re on the cycle after accept with mem_addr=21'h004401; vid_rd_ack one cycle at accept+2 with vid_data=8'h41.
- Chroni-style back-to-back: on ack, the requester switches to addr {8'd65,3'd3} and keeps rd_req high -> second mem_addr reflects the new address; ack spacing = 4 cycles; no stale-address access.
- CPU write 8'hA5 to 21'h000010, then CPU read of the same address -> mem_we one cycle; cpu_ack the next cycle; the read returns cpu_rdata=8'hA5.
- Contention: vid_rd_req held high continuously plus cpu_re held -> exactly 4 video acks, then one CPU ack, repeating; the CPU is never starved.
- cpu_we=cpu_re=1 simultaneously -> performs a write only; mem_re stays 0; one cpu_ack.
